// File: rtl/sseg_capture_pkg.sv
// Shared constants for the 7-segment capture path: canonical gfedcba glyphs,
// 4-bit decode codes and the scan-FSM state encoding.
package sseg_capture_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] CODE_MAX_DIGIT = 4'd9;
    localparam logic [3:0] CODE_MINUS     = 4'd10;
    localparam logic [3:0] CODE_BLANK     = 4'd11;
    localparam logic [3:0] CODE_INVALID   = 4'd15;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } scan_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sseg_decode.sv
// Combinational glyph decoder: canonical active-high gfedcba pattern to a
// 4-bit digit/minus/blank/invalid code.
module sseg_decode
    import sseg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] code
);

    always_comb begin
        code = CODE_INVALID;
        case (seg)
            SEG_0:     code = 4'd0;
            SEG_1:     code = 4'd1;
            SEG_2:     code = 4'd2;
            SEG_3:     code = 4'd3;
            SEG_4:     code = 4'd4;
            SEG_5:     code = 4'd5;
            SEG_6:     code = 4'd6;
            SEG_7:     code = 4'd7;
            SEG_8:     code = 4'd8;
            SEG_9:     code = 4'd9;
            SEG_MINUS: code = CODE_MINUS;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_INVALID;
        endcase
    end

endmodule

// File: rtl/sseg_capture.sv
// Reconstructs the signed 9-bit value shown on a scanned 4-digit display and
// publishes it after two identical frames. Optional stale detector: SSEG_STALE_TIMEOUT_EN.
module sseg_capture
    import sseg_capture_pkg::*;
#(
    parameter int SETTLE_CYC     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter int TIMEOUT_CYC    = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] SSeg,
    input  logic [3:0] an,
    output logic [8:0] resultado,
    output logic       valid,
    output logic       new_value,
    output logic       err,
    output logic       stale
);

    localparam int SET_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
    localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);

    logic [6:0]       seg_norm;
    logic [3:0]       an_norm;
    logic [3:0]       seg_code;
    logic [3:0]       an_lat;
    logic             an_moved;
    scan_state_t      state, state_next;
    logic [SET_W-1:0] settle_cnt;
    logic             capture_en;
    logic [3:0]       mask, mask_merged;
    logic             frame_done, eval_q;
    logic [3:0]       slot [4];
    logic [9:0]       mag;
    logic             frame_ok;
    logic [8:0]       frame_val;
    logic [8:0]       prev_val;
    logic             prev_ok;
    logic             stale_raise;

    assign seg_norm = SEG_ACTIVE_LOW ? ~SSeg : SSeg;
    assign an_norm  = AN_ACTIVE_LOW ? ~an : an;
    assign an_moved = (an_norm != an_lat);

    sseg_decode u_decode (
        .seg  (seg_norm),
        .code (seg_code)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:    if (is_onehot4(an_norm)) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (an_moved)                    state_next = ST_WAIT;
                else if (settle_cnt == '0)       state_next = ST_CAPTURE;
            end
            ST_CAPTURE:                          state_next = ST_HOLD;
            ST_HOLD:    if (an_moved)            state_next = ST_WAIT;
            default:                             state_next = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_WAIT;
            an_lat     <= 4'd0;
            settle_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == ST_WAIT && is_onehot4(an_norm)) begin
                an_lat     <= an_norm;
                settle_cnt <= SET_LOAD;
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
        end
    end

    // an_lat is one-hot while capturing, so it doubles as the slot select.
    assign capture_en  = (state == ST_CAPTURE);
    assign mask_merged = mask | (capture_en ? an_lat : 4'd0);
    assign frame_done  = capture_en && (mask_merged == 4'b1111);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask   <= 4'd0;
            eval_q <= 1'b0;
            for (int i = 0; i < 4; i++) slot[i] <= 4'd0;
        end else begin
            eval_q <= frame_done;
            if (stale_raise || frame_done) mask <= 4'd0;
            else                           mask <= mask_merged;
            for (int i = 0; i < 4; i++) begin
                if (capture_en && an_lat[i]) slot[i] <= seg_code;
            end
        end
    end

    always_comb begin
        mag = 10'(slot[2]) * 10'd100 + 10'(slot[1]) * 10'd10 + 10'(slot[0]);
        frame_ok = (slot[3] == 4'd0 || slot[3] == CODE_BLANK || slot[3] == CODE_MINUS)
                && (slot[2] <= CODE_MAX_DIGIT)
                && (slot[1] <= CODE_MAX_DIGIT)
                && (slot[0] <= CODE_MAX_DIGIT)
                && (mag <= 10'd255);
        frame_val = (slot[3] == CODE_MINUS) ? (~mag[8:0] + 9'd1) : mag[8:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resultado <= 9'd0;
            valid     <= 1'b0;
            new_value <= 1'b0;
            err       <= 1'b0;
            prev_val  <= 9'd0;
            prev_ok   <= 1'b0;
        end else begin
            new_value <= 1'b0;
            err       <= 1'b0;
            if (eval_q) begin
                if (!frame_ok) begin
                    err     <= 1'b1;
                    prev_ok <= 1'b0;
                end else begin
                    prev_val <= frame_val;
                    prev_ok  <= 1'b1;
                    if (prev_ok && prev_val == frame_val) begin
                        resultado <= frame_val;
                        valid     <= 1'b1;
                        new_value <= !valid || (frame_val != resultado);
                    end
                end
            end
            // A stale display invalidates any half-confirmed frame.
            if (stale_raise) prev_ok <= 1'b0;
        end
    end

`ifdef SSEG_STALE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

    logic [IDLE_W-1:0] idle_cnt;
    logic [3:0]        an_prev;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            an_prev  <= 4'd0;
        end else begin
            an_prev <= an_norm;
            if (an_norm != an_prev)   idle_cnt <= '0;
            else if (idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    assign stale       = (idle_cnt == IDLE_MAX);
    assign stale_raise = (an_norm == an_prev) && (idle_cnt == IDLE_MAX - IDLE_W'(1));
`else
    // Always 0 for any legal TIMEOUT_CYC; no idle counter exists in this build.
    assign stale       = (TIMEOUT_CYC < 0);
    assign stale_raise = 1'b0;
`endif

endmodule

// File: tb/tb_sseg_capture.sv
// Directed bench for sseg_capture: table of scanned frames with expected
// outputs, plus hand-written glitch, reset and stale sequences.
module tb_sseg_capture;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] SSeg;
    logic [3:0] an;
    logic [8:0] resultado;
    logic       valid;
    logic       new_value;
    logic       err;
    logic       stale;

    int checks = 0;
    int errors = 0;
    int nv_cnt = 0;
    int err_cnt = 0;

    // Active-low wire values of each glyph.
    localparam logic [6:0] W0 = 7'h40, W1 = 7'h79, W2 = 7'h24, W3 = 7'h30, W4 = 7'h19;
    localparam logic [6:0] W5 = 7'h12, W6 = 7'h02, W7 = 7'h78, W8 = 7'h00;
    localparam logic [6:0] WMIN = 7'h3F, WBLK = 7'h7F, WA = 7'h08;

    typedef struct {
        logic [6:0] w3, w2, w1, w0;
        logic [8:0] res;
        logic       vld;
        int         nv;
        int         er;
    } vec_t;

    vec_t vecs [19];

    sseg_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SSeg      (SSeg),
        .an        (an),
        .resultado (resultado),
        .valid     (valid),
        .new_value (new_value),
        .err       (err),
        .stale     (stale)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (new_value === 1'b1) nv_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an_wire, input logic [6:0] seg_wire, input int cycles);
        an   = an_wire;
        SSeg = seg_wire;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send_digit(input int idx, input logic [6:0] w, input int dwell);
        drive(~(4'b0001 << idx), w, dwell);
    endtask

    task automatic send_frame(input logic [6:0] w3, w2, w1, w0);
        send_digit(3, w3, 10);
        send_digit(2, w2, 10);
        send_digit(1, w1, 10);
        send_digit(0, w0, 10);
    endtask

    task automatic clear_counts();
        nv_cnt  = 0;
        err_cnt = 0;
    endtask

    task automatic check_frame(input string tag, input logic [8:0] res, input logic vld, input int nv, input int er);
        check({tag, " resultado"}, int'(resultado), int'(res));
        check({tag, " valid"}, int'(valid), int'(vld));
        check({tag, " new_value pulses"}, nv_cnt, nv);
        check({tag, " err pulses"}, err_cnt, er);
    endtask

    initial begin
        vecs[0]  = '{W0, W0, W0, W2, 9'h000, 1'b0, 0, 0};
        vecs[1]  = '{W0, W0, W0, W2, 9'h002, 1'b1, 1, 0};
        vecs[2]  = '{WMIN, W0, W0, W2, 9'h002, 1'b1, 0, 0};
        vecs[3]  = '{WMIN, W0, W0, W2, 9'h1FE, 1'b1, 1, 0};
        vecs[4]  = '{WMIN, W2, W5, W5, 9'h1FE, 1'b1, 0, 0};
        vecs[5]  = '{WMIN, W2, W5, W5, 9'h101, 1'b1, 1, 0};
        vecs[6]  = '{W0, W2, W5, W6, 9'h101, 1'b1, 0, 1};
        vecs[7]  = '{W0, W2, W5, W6, 9'h101, 1'b1, 0, 1};
        vecs[8]  = '{W0, WA, W0, W2, 9'h101, 1'b1, 0, 1};
        vecs[9]  = '{W0, W1, W2, W8, 9'h101, 1'b1, 0, 0};
        vecs[10] = '{W0, W1, W2, W7, 9'h101, 1'b1, 0, 0};
        vecs[11] = '{W0, W1, W2, W8, 9'h101, 1'b1, 0, 0};
        vecs[12] = '{W0, W1, W2, W7, 9'h101, 1'b1, 0, 0};
        vecs[13] = '{W0, W1, W2, W7, 9'h07F, 1'b1, 1, 0};
        vecs[14] = '{W0, W1, W2, W7, 9'h07F, 1'b1, 0, 0};
        vecs[15] = '{WMIN, W0, W0, W0, 9'h07F, 1'b1, 0, 0};
        vecs[16] = '{WMIN, W0, W0, W0, 9'h000, 1'b1, 1, 0};
        vecs[17] = '{WBLK, W2, W5, W5, 9'h000, 1'b1, 0, 0};
        vecs[18] = '{WBLK, W2, W5, W5, 9'h0FF, 1'b1, 1, 0};

        rst_n = 1'b0;
        an    = 4'hF;
        SSeg  = WBLK;
        repeat (3) @(negedge clk);
        check("reset resultado", int'(resultado), 0);
        check("reset valid", int'(valid), 0);
        check("reset new_value", int'(new_value), 0);
        check("reset err", int'(err), 0);
        check("reset stale", int'(stale), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 19; i++) begin
            clear_counts();
            send_frame(vecs[i].w3, vecs[i].w2, vecs[i].w1, vecs[i].w0);
            check_frame($sformatf("vec%0d", i), vecs[i].res, vecs[i].vld, vecs[i].nv, vecs[i].er);
        end

        // Glitchy and short dwells on slot 2 must not capture it.
        clear_counts();
        send_digit(3, W0, 10);
        drive(4'b1011, W0, 2);
        drive(4'b1111, W0, 1);
        drive(4'b1011, W0, 3);
        drive(4'b1100, W0, 1);
        send_digit(1, W0, 10);
        send_digit(0, W3, 10);
        check_frame("glitch partial", 9'h0FF, 1'b1, 0, 0);
        send_digit(2, W0, 10);
        check_frame("glitch completed", 9'h0FF, 1'b1, 0, 0);
        clear_counts();
        send_frame(W0, W0, W0, W3);
        check_frame("glitch confirm", 9'h003, 1'b1, 1, 0);

        // One-cycle reset mid-frame.
        send_digit(3, W0, 10);
        send_digit(2, W0, 10);
        rst_n = 1'b0;
        an    = 4'hF;
        @(negedge clk);
        check("midreset resultado", int'(resultado), 0);
        check("midreset valid", int'(valid), 0);
        check("midreset new_value", int'(new_value), 0);
        check("midreset err", int'(err), 0);
        check("midreset stale", int'(stale), 0);
        rst_n = 1'b1;
        clear_counts();
        send_digit(1, W0, 10);
        send_digit(0, W4, 10);
        send_digit(3, W0, 10);
        send_digit(2, W0, 10);
        check_frame("post-reset first", 9'h000, 1'b0, 0, 0);
        send_digit(1, W0, 10);
        send_digit(0, W4, 10);
        send_digit(3, W0, 10);
        send_digit(2, W0, 10);
        check_frame("post-reset second", 9'h004, 1'b1, 1, 0);

`ifdef SSEG_STALE_TIMEOUT_EN
        repeat (4100) @(negedge clk);
        check("stale after freeze", int'(stale), 1);
        send_digit(3, W0, 10);
        check("stale cleared", int'(stale), 0);
`else
        repeat (100) @(negedge clk);
        check("stale tied low", int'(stale), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
